// File: rtl/cmp_result_accumulator.sv
// Tallies threebit comparator outcomes over WINDOW accepted samples and holds a report.
// Optional build macro CMP_ONEHOT_CHECK_EN: non-one-hot samples are discarded and flagged.
module cmp_result_accumulator #(
  parameter int WINDOW = 8,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             A_greater_B,
  input  logic             A_equal_B,
  input  logic             A_smaller_B,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] lt_count,
  output logic [1:0]       majority
`ifdef CMP_ONEHOT_CHECK_EN
  ,
  output logic             onehot_err
`endif
);

  typedef enum logic [0:0] {ST_ACCUM = 1'b0, ST_REPORT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] gt_acc_q, gt_acc_d, eq_acc_q, eq_acc_d, lt_acc_q, lt_acc_d;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d, eq_cnt_q, eq_cnt_d, lt_cnt_q, lt_cnt_d;
  logic [CNT_W-1:0] gt_sum_s, eq_sum_s, lt_sum_s;
  logic [1:0]       maj_q, maj_d;
  logic             in_ready_s, rpt_valid_s;
  logic             accept_s, counted_s, close_s, handshake_s, onehot_s;

  // Strictly greatest count wins; any tie for the maximum reports 2'b00.
  function automatic logic [1:0] majority_of(input logic [CNT_W-1:0] g,
                                             input logic [CNT_W-1:0] e,
                                             input logic [CNT_W-1:0] l);
    logic [1:0] code;
    if ((g > e) && (g > l)) begin
      code = 2'b01;
    end else if ((e > g) && (e > l)) begin
      code = 2'b10;
    end else if ((l > g) && (l > e)) begin
      code = 2'b11;
    end else begin
      code = 2'b00;
    end
    return code;
  endfunction

  assign onehot_s    = (({2'b00, A_greater_B} + {2'b00, A_equal_B} + {2'b00, A_smaller_B}) == 3'd1);
  assign accept_s    = in_valid && in_ready_s;
  assign handshake_s = rpt_valid_s && rpt_ready;
`ifdef CMP_ONEHOT_CHECK_EN
  assign counted_s   = accept_s && onehot_s;
`else
  assign counted_s   = accept_s;
`endif
  assign close_s     = counted_s && (idx_q == CNT_W'(WINDOW - 1));
  assign gt_sum_s    = gt_acc_q + CNT_W'(counted_s && A_greater_B);
  assign eq_sum_s    = eq_acc_q + CNT_W'(counted_s && A_equal_B);
  assign lt_sum_s    = lt_acc_q + CNT_W'(counted_s && A_smaller_B);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: begin
        if (close_s) state_d = ST_REPORT;
        else         state_d = ST_ACCUM;
      end
      ST_REPORT: begin
        if (rpt_ready) state_d = ST_ACCUM;
        else           state_d = ST_REPORT;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // FSM output decode.
  always_comb begin
    in_ready_s  = 1'b0;
    rpt_valid_s = 1'b0;
    case (state_q)
      ST_ACCUM:  in_ready_s  = 1'b1;
      ST_REPORT: rpt_valid_s = 1'b1;
      default: begin
        in_ready_s  = 1'b0;
        rpt_valid_s = 1'b0;
      end
    endcase
  end

  // Window accumulation; the closing sample is folded into the latched report.
  always_comb begin
    gt_cnt_d = gt_cnt_q;
    eq_cnt_d = eq_cnt_q;
    lt_cnt_d = lt_cnt_q;
    maj_d    = maj_q;
    if (close_s) begin
      gt_acc_d = {CNT_W{1'b0}};
      eq_acc_d = {CNT_W{1'b0}};
      lt_acc_d = {CNT_W{1'b0}};
      idx_d    = {CNT_W{1'b0}};
      gt_cnt_d = gt_sum_s;
      eq_cnt_d = eq_sum_s;
      lt_cnt_d = lt_sum_s;
      maj_d    = majority_of(gt_sum_s, eq_sum_s, lt_sum_s);
    end else begin
      gt_acc_d = gt_sum_s;
      eq_acc_d = eq_sum_s;
      lt_acc_d = lt_sum_s;
      idx_d    = idx_q + CNT_W'(counted_s);
    end
  end

  // Accumulator and report registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= {CNT_W{1'b0}};
      gt_acc_q <= {CNT_W{1'b0}};
      eq_acc_q <= {CNT_W{1'b0}};
      lt_acc_q <= {CNT_W{1'b0}};
      gt_cnt_q <= {CNT_W{1'b0}};
      eq_cnt_q <= {CNT_W{1'b0}};
      lt_cnt_q <= {CNT_W{1'b0}};
      maj_q    <= 2'b00;
    end else begin
      idx_q    <= idx_d;
      gt_acc_q <= gt_acc_d;
      eq_acc_q <= eq_acc_d;
      lt_acc_q <= lt_acc_d;
      gt_cnt_q <= gt_cnt_d;
      eq_cnt_q <= eq_cnt_d;
      lt_cnt_q <= lt_cnt_d;
      maj_q    <= maj_d;
    end
  end

`ifdef CMP_ONEHOT_CHECK_EN
  logic err_q, err_d;

  // Sticky encoding error; a new bad sample outranks the report-handshake clear.
  always_comb begin
    if (accept_s && !onehot_s) begin
      err_d = 1'b1;
    end else if (handshake_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign onehot_err = err_q;
`endif

  assign in_ready  = in_ready_s;
  assign rpt_valid = rpt_valid_s;
  assign gt_count  = gt_cnt_q;
  assign eq_count  = eq_cnt_q;
  assign lt_count  = lt_cnt_q;
  assign majority  = maj_q;

endmodule

// File: tb/tb_cmp_result_accumulator.sv
// Self-checking bench for cmp_result_accumulator (WINDOW=4): directed table,
// hand-written corner sequences and randomized traffic against a queue-based model.
module tb_cmp_result_accumulator;
  localparam int WINDOW = 4;
  localparam int CNT_W  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0, in_ready;
  logic             A_greater_B = 1'b0, A_equal_B = 1'b0, A_smaller_B = 1'b0;
  logic             rpt_valid, rpt_ready = 1'b0;
  logic [CNT_W-1:0] gt_count, eq_count, lt_count;
  logic [1:0]       majority;
`ifdef CMP_ONEHOT_CHECK_EN
  logic             onehot_err;
`endif

  cmp_result_accumulator #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A_greater_B(A_greater_B), .A_equal_B(A_equal_B), .A_smaller_B(A_smaller_B),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .gt_count(gt_count), .eq_count(eq_count), .lt_count(lt_count),
    .majority(majority)
`ifdef CMP_ONEHOT_CHECK_EN
    , .onehot_err(onehot_err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: pending report flag, queue of counted samples, expected report.
  bit         m_pend;
  bit         m_err;
  int         m_gt, m_eq, m_lt;
  logic [1:0] m_maj;
  logic [2:0] m_win[$];

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  typedef struct {
    logic [3:0][2:0] f;
    int              g, e, l;
    logic [1:0]      maj;
  } vec_t;

  vec_t tbl[4];

  function automatic logic [1:0] ref_maj(input int g, input int e, input int l);
    int c[3];
    int mx, hits, who;
    c[0] = g; c[1] = e; c[2] = l;
    mx = 0; hits = 0; who = 0;
    for (int i = 0; i < 3; i++) if (c[i] > mx) mx = c[i];
    for (int i = 0; i < 3; i++) if (c[i] == mx) begin hits++; who = i; end
    return (hits == 1) ? 2'(who + 1) : 2'b00;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("in_ready", int'(in_ready), int'(!m_pend));
    chk("rpt_valid", int'(rpt_valid), int'(m_pend));
    chk("gt_count", int'(gt_count), m_gt);
    chk("eq_count", int'(eq_count), m_eq);
    chk("lt_count", int'(lt_count), m_lt);
    chk("majority", int'(majority), int'(m_maj));
`ifdef CMP_ONEHOT_CHECK_EN
    chk("onehot_err", int'(onehot_err), int'(m_err));
`endif
  endtask

  // One clock cycle: check outputs, drive inputs, advance model, step past the edge.
  task automatic cycle(input bit v, input logic [2:0] f, input bit rr);
    int g, e, l;
    model_check();
    in_valid = v;
    {A_greater_B, A_equal_B, A_smaller_B} = f;
    rpt_ready = rr;
    if (m_pend) begin
      if (rr) begin
        m_pend = 1'b0;
        m_err  = 1'b0;
      end
    end else if (v) begin
`ifdef CMP_ONEHOT_CHECK_EN
      if ($countones(f) != 1) m_err = 1'b1;
      else m_win.push_back(f);
`else
      m_win.push_back(f);
`endif
      if (m_win.size() == WINDOW) begin
        g = 0; e = 0; l = 0;
        foreach (m_win[i]) begin
          g += int'(m_win[i][2]);
          e += int'(m_win[i][1]);
          l += int'(m_win[i][0]);
        end
        m_gt = g; m_eq = e; m_lt = l;
        m_maj = ref_maj(g, e, l);
        m_win.delete();
        m_pend = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    #2;
    m_pend = 1'b0; m_err = 1'b0;
    m_gt = 0; m_eq = 0; m_lt = 0; m_maj = 2'b00;
    m_win.delete();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_rpt_valid", int'(rpt_valid), 0);
    chk("rst_counts", int'({gt_count, eq_count, lt_count}), 0);
    chk("rst_majority", int'(majority), 0);
`ifdef CMP_ONEHOT_CHECK_EN
    chk("rst_onehot_err", int'(onehot_err), 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{f: {GT, GT, EQ, LT}, g: 2, e: 1, l: 1, maj: 2'b01};
    tbl[1] = '{f: {GT, GT, LT, LT}, g: 2, e: 0, l: 2, maj: 2'b00};
    tbl[2] = '{f: {EQ, EQ, EQ, EQ}, g: 0, e: 4, l: 0, maj: 2'b10};
    tbl[3] = '{f: {LT, GT, LT, LT}, g: 1, e: 0, l: 3, maj: 2'b11};

    do_reset();

    // Directed windows, consumer always ready: report lasts exactly one cycle.
    foreach (tbl[i]) begin
      for (int k = 3; k >= 0; k--) cycle(1'b1, tbl[i].f[k], 1'b1);
      chk("tbl_rpt_valid", int'(rpt_valid), 1);
      chk("tbl_gt", int'(gt_count), tbl[i].g);
      chk("tbl_eq", int'(eq_count), tbl[i].e);
      chk("tbl_lt", int'(lt_count), tbl[i].l);
      chk("tbl_maj", int'(majority), int'(tbl[i].maj));
      cycle(1'b0, 3'b000, 1'b1);
      chk("tbl_rpt_drop", int'(rpt_valid), 0);
      chk("tbl_ready_back", int'(in_ready), 1);
    end

    // Consumer stalls five cycles while samples keep arriving.
    cycle(1'b1, GT, 1'b1); cycle(1'b1, GT, 1'b1);
    cycle(1'b1, EQ, 1'b1); cycle(1'b1, LT, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, GT, 1'b0);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_rpt_valid", int'(rpt_valid), 1);
      chk("stall_gt_held", int'(gt_count), 2);
      chk("stall_maj_held", int'(majority), 1);
    end
    cycle(1'b1, GT, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b1, EQ, 1'b1);
    chk("post_stall_eq", int'(eq_count), 4);
    chk("post_stall_gt", int'(gt_count), 0);
    cycle(1'b0, 3'b000, 1'b1);

    // Multi-hot sample (gt and lt together) followed by three eq samples.
    cycle(1'b1, 3'b101, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b1, EQ, 1'b1);
`ifdef CMP_ONEHOT_CHECK_EN
    chk("oh_no_report", int'(rpt_valid), 0);
    chk("oh_err_set", int'(onehot_err), 1);
    cycle(1'b1, EQ, 1'b1);
    chk("oh_rpt_valid", int'(rpt_valid), 1);
    chk("oh_eq", int'(eq_count), 4);
    chk("oh_maj", int'(majority), 2);
    cycle(1'b0, 3'b000, 1'b1);
    chk("oh_err_clear", int'(onehot_err), 0);
`else
    chk("mh_rpt_valid", int'(rpt_valid), 1);
    chk("mh_gt", int'(gt_count), 1);
    chk("mh_eq", int'(eq_count), 3);
    chk("mh_lt", int'(lt_count), 1);
    chk("mh_maj", int'(majority), 2);
    cycle(1'b0, 3'b000, 1'b1);
`endif

    // Reset after two samples discards the partial window.
    cycle(1'b1, GT, 1'b1); cycle(1'b1, GT, 1'b1);
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b1, LT, 1'b1);
    chk("rstwin_lt", int'(lt_count), 4);
    chk("rstwin_gt", int'(gt_count), 0);
    chk("rstwin_maj", int'(majority), 3);
    cycle(1'b0, 3'b000, 1'b1);

    // Randomized traffic with occasional bad encodings, stalls and resets.
    for (int n = 0; n < 600; n++) begin
      logic [2:0] f;
      if ($urandom_range(0, 7) == 0) f = 3'($urandom_range(0, 7));
      else f = 3'b001 << $urandom_range(0, 2);
      if ($urandom_range(0, 249) == 0) do_reset();
      cycle($urandom_range(0, 3) != 0, f, $urandom_range(0, 2) != 0);
    end
    model_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
